// File: rtl/caliptra_prim_sum_split.sv
// caliptra_prim_sum_split: sequential budget splitter.
// Takes one total and a per-lane cap vector, then grants up to each lane's cap,
// one lane per cycle, until the total runs out or every lane has been visited.
// The optional define CALIPTRA_PRIM_SUM_SPLIT_ROTATE_EN rotates the first lane
// after every completed response so that first-lane priority is shared fairly.

// Holds one lane's registered grant and valid flag.
module caliptra_prim_sum_split_lane #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             we,
  input  logic [Width-1:0] grant,
  output logic [Width-1:0] value,
  output logic             valid
);

  // Clear on acceptance; load when the allocator visits this lane.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      value <= '0;
      valid <= 1'b0;
    end else if (we) begin
      value <= grant;
      valid <= |grant;
    end
  end

endmodule

module caliptra_prim_sum_split #(
  parameter int NumSrc = 32,
  parameter int Width  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [Width-1:0]              total_i,
  input  logic [NumSrc-1:0][Width-1:0]  caps_i,
  input  logic [NumSrc-1:0]             caps_valid_i,
  output logic [NumSrc-1:0][Width-1:0]  values_o,
  output logic [NumSrc-1:0]             valid_o,
  output logic [Width-1:0]              remainder_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i
);

  localparam int IdxW = $clog2(NumSrc);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [NumSrc-1:0][Width-1:0]  caps_q;
  logic [NumSrc-1:0]             caps_valid_q;
  logic [Width-1:0]              rem_q, rem_next, cap_sel, grant;
  logic [IdxW-1:0]               idx_q, idx_next, start_ptr;
  logic [IdxW-1:0]               cnt_q;
  logic                          accept, alloc, last;

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign accept      = req_valid_i & req_ready_o;
  assign alloc       = (state_q == ALLOC);

  // Grant for the lane under the pointer: capped by both the remaining budget
  // and the lane cap, zero for ineligible lanes. grant <= rem so no underflow.
  always_comb begin
    cap_sel  = caps_q[idx_q];
    grant    = '0;
    if (caps_valid_q[idx_q]) grant = (rem_q < cap_sel) ? rem_q : cap_sel;
    rem_next = rem_q - grant;
    last     = (rem_next == '0) || (cnt_q == IdxW'(NumSrc - 1));
    idx_next = (idx_q == IdxW'(NumSrc - 1)) ? '0 : idx_q + 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (total_i == '0) ? DONE : ALLOC;
      ALLOC:   if (last) state_d = DONE;
      DONE:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request capture and allocation bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      caps_q       <= '0;
      caps_valid_q <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      remainder_o  <= '0;
    end else if (accept) begin
      caps_q       <= caps_i;
      caps_valid_q <= caps_valid_i;
      rem_q        <= total_i;
      idx_q        <= start_ptr;
      cnt_q        <= '0;
      remainder_o  <= '0;
    end else if (alloc) begin
      rem_q <= rem_next;
      idx_q <= idx_next;
      cnt_q <= cnt_q + 1'b1;
      if (last) remainder_o <= rem_next;
    end
  end

`ifdef CALIPTRA_PRIM_SUM_SPLIT_ROTATE_EN
  // First-lane pointer advances once per completed response handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) start_ptr <= '0;
    else if (rsp_valid_o && rsp_ready_i)
      start_ptr <= (start_ptr == IdxW'(NumSrc - 1)) ? '0 : start_ptr + 1'b1;
  end
`else
  assign start_ptr = '0;
`endif

  // Per-lane output registers.
  for (genvar i = 0; i < NumSrc; i++) begin : g_lane
    caliptra_prim_sum_split_lane #(.Width(Width)) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (accept),
      .we    (alloc && (idx_q == IdxW'(i))),
      .grant (grant),
      .value (values_o[i]),
      .valid (valid_o[i])
    );
  end

endmodule

// File: tb/tb_caliptra_prim_sum_split.sv
// Self-checking bench for caliptra_prim_sum_split (NumSrc=4, Width=8).
// Expected results come from a lane-walk model of the allocation rules.
module tb_caliptra_prim_sum_split;

  localparam int N = 4;
  localparam int W = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0]          total, remainder;
  logic [N-1:0][W-1:0]   caps, values;
  logic [N-1:0]          caps_valid, valid;

  int checks   = 0;
  int failures = 0;
  int exp_ptr  = 0;

  caliptra_prim_sum_split #(.NumSrc(N), .Width(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .total_i      (total),
    .caps_i       (caps),
    .caps_valid_i (caps_valid),
    .values_o     (values),
    .valid_o      (valid),
    .remainder_o  (remainder),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready)
  );

  always #5 clk = ~clk;

  // Reference: walk lanes from the start pointer, handing out min(left, cap)
  // to eligible lanes until nothing is left or all lanes were seen.
  function automatic void model(input logic [W-1:0] tot, input logic [N-1:0][W-1:0] c,
                                input logic [N-1:0] cv, input int start,
                                output logic [N-1:0][W-1:0] ev, output logic [N-1:0] evl,
                                output logic [W-1:0] erem, output int k);
    int left, g, lane;
    left = tot; k = 0; ev = '0; evl = '0;
    if (tot != 0) begin
      for (int i = 0; i < N && left != 0; i++) begin
        lane = (start + i) % N;
        g = cv[lane] ? ((left < int'(c[lane])) ? left : int'(c[lane])) : 0;
        ev[lane]  = W'(g);
        evl[lane] = (g != 0);
        left -= g;
        k++;
      end
    end
    erem = W'(left);
  endfunction

  // Drives one request, scrambles the inputs after acceptance, and returns the
  // number of rising edges after the acceptance edge until rsp_valid is seen.
  task automatic issue(input logic [W-1:0] t, input logic [N-1:0][W-1:0] c,
                       input logic [N-1:0] cv, output int lat);
    @(negedge clk);
    req_valid = 1'b1; total = t; caps = c; caps_valid = cv;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total = W'($urandom); caps = {N{W'($urandom)}}; caps_valid = N'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  // Completes the response handshake and tracks the rotating start lane.
  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
`ifdef CALIPTRA_PRIM_SUM_SPLIT_ROTATE_EN
    exp_ptr = (exp_ptr + 1) % N;
`endif
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    total = '0; caps = '0; caps_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || values !== '0 || valid !== '0 || remainder !== '0) begin
      failures++;
      $display("FAIL reset: rdy=%b rv=%b vals=%h vld=%b rem=%0d, want 1 0 0 0 0",
               req_ready, rsp_valid, values, valid, remainder);
    end
    rst = 1'b0;
    exp_ptr = 0;
    @(negedge clk);
  endtask

  // Runs one request against the model and checks every output plus latency.
  task automatic test_case(input string name, input logic [W-1:0] t,
                           input logic [N-1:0][W-1:0] c, input logic [N-1:0] cv);
    logic [N-1:0][W-1:0] ev;
    logic [N-1:0] evl;
    logic [W-1:0] erem, sum;
    int k, lat;
    model(t, c, cv, exp_ptr, ev, evl, erem, k);
    issue(t, c, cv, lat);
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL %s timeout: rsp_valid never rose", name);
    end
    checks++;
    if (lat !== k) begin
      failures++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, lat, k);
    end
    checks++;
    if (values !== ev || valid !== evl || remainder !== erem) begin
      failures++;
      $display("FAIL %s result: vals=%h vld=%b rem=%0d, want vals=%h vld=%b rem=%0d",
               name, values, valid, remainder, ev, evl, erem);
    end
    sum = remainder;
    for (int i = 0; i < N; i++) if (valid[i]) sum += values[i];
    checks++;
    if (sum !== t) begin
      failures++;
      $display("FAIL %s invariant: sum+rem=%0d, want %0d", name, sum, t);
    end
    finish_rsp();
  endtask

  task automatic test_directed();
    test_case("basic_fill", 8'd10, {8'd5, 8'd5, 8'd5, 8'd5}, 4'b1111);
    test_case("excess",     8'd30, {8'd5, 8'd5, 8'd5, 8'd5}, 4'b1111);
    test_case("ineligible", 8'd7,  {8'd4, 8'd4, 8'd4, 8'd4}, 4'b0101);
    test_case("zero_total", 8'd0,  {8'd9, 8'd9, 8'd9, 8'd9}, 4'b1111);
    test_case("zero_caps",  8'd20, {8'd0, 8'd3, 8'd0, 8'd0}, 4'b1111);
    test_case("max_total",  8'd255, {8'd255, 8'd1, 8'd1, 8'd1}, 4'b1111);
  endtask

  task automatic test_backpressure();
    logic [N-1:0][W-1:0] v0;
    logic [N-1:0] vl0;
    logic [W-1:0] r0;
    int lat, bad;
    issue(8'd10, {8'd5, 8'd5, 8'd5, 8'd5}, 4'b1111, lat);
    v0 = values; vl0 = valid; r0 = remainder;
    bad = 0;
    req_valid = 1'b1; total = 8'd99; caps = {N{8'd50}}; caps_valid = '1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (values !== v0 || valid !== vl0 || remainder !== r0 || req_ready !== 1'b0 || rsp_valid !== 1'b1)
        bad++;
    end
    req_valid = 1'b0;
    checks++;
    if (bad != 0 || v0 !== {8'd0, 8'd0, 8'd5, 8'd5} || vl0 !== 4'b0011) begin
      failures++;
      $display("FAIL backpressure: %0d unstable cycles, vals=%h vld=%b", bad, v0, vl0);
    end
    finish_rsp();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_handshake: rdy=%b rv=%b, want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_alloc();
    @(negedge clk);
    req_valid = 1'b1; total = 8'd30; caps = {N{8'd5}}; caps_valid = '1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || values !== '0 || valid !== '0 || remainder !== '0) begin
      failures++;
      $display("FAIL reset_mid_alloc: rdy=%b rv=%b vals=%h vld=%b rem=%0d, want 1 0 0 0 0",
               req_ready, rsp_valid, values, valid, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [N-1:0] first_vld, second_vld, want2;
    int lat;
    issue(8'd5, {N{8'd5}}, 4'b1111, lat);
    first_vld = valid;
    finish_rsp();
    issue(8'd5, {N{8'd5}}, 4'b1111, lat);
    second_vld = valid;
    finish_rsp();
`ifdef CALIPTRA_PRIM_SUM_SPLIT_ROTATE_EN
    want2 = 4'b0010;
`else
    want2 = 4'b0001;
`endif
    checks++;
    if (first_vld !== 4'b0001 || second_vld !== want2) begin
      failures++;
      $display("FAIL rotation: vld1=%b vld2=%b, want 0001 %b", first_vld, second_vld, want2);
    end
  endtask

  task automatic test_random();
    logic [N-1:0][W-1:0] c;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < N; i++) c[i] = W'($urandom_range(0, 80));
      test_case("random", (n % 5 == 0) ? W'($urandom_range(0, 3)) : W'($urandom),
                c, N'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_alloc();
    test_rotation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
